// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes one latched word as start / data (LSB first) / optional parity / stop.
// Bit time is a latched prescale count; TX_OUT and BUSY come straight from flops.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      wrap;

  assign wrap = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = wrap ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
    prescale_d = prescale_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        if (DATA_VALID) begin
          shift_d    = P_DATA;
          par_en_d   = PAR_EN;
          par_bit_d  = PAR_TYP ? ~^P_DATA : ^P_DATA;
          prescale_d = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (wrap) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (wrap) begin
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            // Last data bit done: parity only if it was enabled at acceptance.
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (wrap) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (wrap) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      prescale_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      prescale_q <= prescale_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level model expands each accepted word into the expected
// per-clock line/busy waveform, checked every cycle, plus mid-bit decoding and busy-length checks.
module tb_uart_tx_serializer;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  uart_tx_serializer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK       (clk),
    .RST       (rst),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .PRESCALE  (prescale),
    .TX_OUT    (tx_out),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per expected clock after each rising edge.
  typedef struct {
    logic tx;
    logic bsy;
    logic mid;
    int   idx;
  } samp_t;

  samp_t         q[$];
  bit            armed    = 0;
  logic          exp_tx   = 1'b1;
  logic          exp_busy = 1'b0;
  logic          exp_mid  = 1'b0;
  int            exp_idx  = -1;
  int            accepts  = 0;
  logic [DW-1:0] cur_data;
  int            cur_nbits;
  int            cur_len;

  task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic [PW-1:0] ps);
    int    p;
    int    nbits;
    logic  b;
    samp_t s;
    p     = (ps == 0) ? 1 : int'(ps);
    nbits = DW + 2 + (pe ? 1 : 0);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= DW) b = d[i-1];
      else if (pe && i == DW + 1) b = pt ? ~^d : ^d;
      else b = 1'b1;
      for (int k = 0; k < p; k++) begin
        s = '{tx: b, bsy: 1'b1, mid: (k == p / 2), idx: i};
        q.push_back(s);
      end
    end
    // Mandatory idle-high clock before the next frame can start.
    s = '{tx: 1'b1, bsy: 1'b0, mid: 1'b0, idx: -1};
    q.push_back(s);
    cur_data  = d;
    cur_nbits = nbits;
    cur_len   = nbits * p;
    accepts++;
  endtask

  always @(posedge clk) begin
    samp_t s;
    if (rst) begin
      q.delete();
      armed    = 1;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_mid  = 1'b0;
      exp_idx  = -1;
      cur_len  = 0;
    end else if (armed) begin
      if (q.size() == 0 && data_valid) build_frame(p_data, par_en, par_typ, prescale);
      if (q.size() > 0) begin
        s        = q.pop_front();
        exp_tx   = s.tx;
        exp_busy = s.bsy;
        exp_mid  = s.mid;
        exp_idx  = s.idx;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        exp_mid  = 1'b0;
        exp_idx  = -1;
      end
    end
  end

  logic [DW-1:0] recon;
  int            busy_run = 0;

  always @(negedge clk) begin
    if (armed) begin
      check_eq("tx_out", tx_out, exp_tx);
      check_eq("busy", busy, exp_busy);
      if (exp_mid && exp_idx >= 1 && exp_idx <= DW) recon[exp_idx-1] = tx_out;
      if (exp_mid && exp_idx == cur_nbits - 1) check_eq("decoded_word", recon, cur_data);
      if (busy === 1'b1) begin
        busy_run++;
      end else begin
        if (busy_run > 0 && cur_len != 0) check_eq("busy_len", busy_run, cur_len);
        busy_run = 0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic [PW-1:0] ps);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_accepts(input int target);
    int n = 0;
    while (accepts < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_timeout", (accepts >= target), 1'b1);
  endtask

  initial begin
    int a0;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    send(8'hAA, 1'b1, 1'b0, 6'd1);
    wait_idle();

    send(8'h16, 1'b1, 1'b1, 6'd8);
    wait_idle();

    // Back-to-back with DATA_VALID held high.
    a0 = accepts;
    @(negedge clk);
    p_data     = 8'hBB;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd4;
    data_valid = 1'b1;
    wait_accepts(a0 + 1);
    p_data = 8'h0B;
    wait_accepts(a0 + 2);
    data_valid = 1'b0;
    wait_idle();

    // Valid pulse and input changes while busy must not disturb the frame.
    send(8'h3C, 1'b1, 1'b0, 6'd4);
    repeat (6) @(negedge clk);
    p_data     = 8'hFF;
    prescale   = 6'd2;
    par_en     = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();

    // Reset during the data bits, then a clean frame.
    send(8'hCC, 1'b0, 1'b0, 6'd2);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'hDD, 1'b1, 1'b1, 6'd3);
    wait_idle();

    // Prescale 0 behaves as 1.
    send(8'h5A, 1'b1, 1'b0, 6'd0);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom), PW'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        p_data     = DW'($urandom);
        prescale   = PW'($urandom);
        par_en     = 1'($urandom);
        par_typ    = 1'($urandom);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
